// File: rtl/zorro2_config_host.sv
// zorro2_config_host -- Zorro II AUTOCONFIG host for a single card.
// Reads the card's type and product nybbles. A 64K board is given the base
// address BASE and any other board is told to shut up. The outcome is reported.
// Optional feature: define CFG_HOST_TIMEOUT_EN to end unanswered bus cycles
// after TMO_CYC clocks. Without it, a cycle ends only on DTACK_n or BERR_n.
module zorro2_config_host #(
    parameter logic [7:0]  BASE    = 8'hE9,
    parameter int unsigned TMO_CYC = 31
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        start,
    output logic [23:1] ADDR,
    output logic        AS_n,
    output logic        UDS_n,
    output logic        LDS_n,
    output logic        RW,
    output logic [3:0]  DOUT,
    output logic        DOE,
    input  logic [3:0]  DIN,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    output logic        CFGOUT_n,
    output logic        busy,
    output logic        done,
    output logic        present,
    output logic        shutup,
    output logic [7:0]  er_type,
    output logic [7:0]  er_product
);
    typedef enum logic [3:0] {
        IDLE, RD_T0, RD_T1, RD_P0, RD_P1, WR_LO, WR_HI, WR_SHUT, FIN
    } state_t;

    // Bus cycle phases: address setup, strobe, write data strobe, wait,
    // strobe release, data release.
    typedef enum logic [2:0] {
        PH_C0, PH_C1, PH_C2, PH_WAIT, PH_END, PH_REL
    } phase_t;

    state_t state_q, state_d;
    phase_t phase_q, phase_d;
    logic   err_q, err_d;
    logic   in_bus, is_wr, start_ok, cyc_last, tmo;

    assign in_bus   = !(state_q inside {IDLE, FIN});
    assign is_wr    = state_q inside {WR_LO, WR_HI, WR_SHUT};
    assign start_ok = start && !in_bus;
    assign cyc_last = in_bus && (phase_q == PH_REL);

    function automatic logic [23:1] bus_addr(input state_t s);
        logic [23:0] a;
        case (s)
            RD_T0:   a = 24'hE80000;
            RD_T1:   a = 24'hE80002;
            RD_P0:   a = 24'hE80004;
            RD_P1:   a = 24'hE80006;
            WR_LO:   a = 24'hE8004A;
            WR_HI:   a = 24'hE80048;
            WR_SHUT: a = 24'hE8004C;
            default: a = '0;
        endcase
        return a[23:1];
    endfunction

    function automatic logic [3:0] wr_data(input state_t s);
        logic [7:0] b;
        b = BASE;
        case (s)
            WR_LO:   return b[3:0];
            WR_HI:   return b[7:4];
            default: return '0;
        endcase
    endfunction

`ifdef CFG_HOST_TIMEOUT_EN
    logic [4:0] tmo_cnt;

    // Count strobed cycles. The count is zero at C1, so AS_n stays low for at most TMO_CYC clocks.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)
            tmo_cnt <= '0;
        else if (phase_q == PH_C0)
            tmo_cnt <= '0;
        else if (phase_q inside {PH_C1, PH_C2, PH_WAIT})
            tmo_cnt <= tmo_cnt + 5'd1;
    end

    assign tmo = (phase_q == PH_WAIT) && (tmo_cnt == 5'(TMO_CYC - 1));
`else
    logic [31:0] tmo_cfg_unused;
    assign tmo_cfg_unused = 32'(TMO_CYC);
    assign tmo            = 1'b0;
`endif

    // State, phase and termination-status registers.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            phase_q <= PH_C0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    // Next state and bus outputs. The outputs are decoded from state and phase.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        err_d    = err_q;
        ADDR     = '0;
        AS_n     = 1'b1;
        UDS_n    = 1'b1;
        LDS_n    = 1'b1;
        RW       = 1'b1;
        DOUT     = '0;
        DOE      = 1'b0;
        busy     = in_bus;
        done     = (state_q == FIN);
        CFGOUT_n = !in_bus;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d = RD_T0;
                    phase_d = PH_C0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                ADDR  = bus_addr(state_q);
                RW    = !is_wr;
                DOUT  = wr_data(state_q);
                AS_n  = !(phase_q inside {PH_C1, PH_C2, PH_WAIT});
                UDS_n = !((phase_q inside {PH_C2, PH_WAIT}) || (phase_q == PH_C1 && !is_wr));
                DOE   = is_wr && (phase_q inside {PH_C1, PH_C2, PH_WAIT, PH_END});
                case (phase_q)
                    PH_C0:   phase_d = PH_C1;
                    PH_C1:   phase_d = is_wr ? PH_C2 : PH_WAIT;
                    PH_C2:   phase_d = PH_WAIT;
                    PH_WAIT: begin
                        if (!DTACK_n || !BERR_n || tmo) begin
                            phase_d = PH_END;
                            // A timeout leaves DTACK_n high. BERR_n wins over DTACK_n.
                            err_d   = DTACK_n || !BERR_n;
                        end
                    end
                    PH_END:  phase_d = PH_REL;
                    PH_REL: begin
                        phase_d = PH_C0;
                        if (err_q)
                            state_d = FIN;
                        else begin
                            case (state_q)
                                RD_T0:   state_d = RD_T1;
                                RD_T1:   state_d = RD_P0;
                                RD_P0:   state_d = RD_P1;
                                RD_P1:   state_d = (er_type[2:0] == 3'b001) ? WR_LO : WR_SHUT;
                                WR_LO:   state_d = WR_HI;
                                default: state_d = FIN;
                            endcase
                        end
                    end
                    default: phase_d = PH_C0;
                endcase
            end
        endcase
    end

    // Outcome flags. They are cleared on an accepted start and settled as each bus cycle completes.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            present <= 1'b0;
            shutup  <= 1'b0;
        end else if (start_ok) begin
            present <= 1'b0;
            shutup  <= 1'b0;
        end else if (cyc_last) begin
            if (err_q) begin
                present <= is_wr;
                shutup  <= 1'b0;
            end else if (state_q == RD_P1)
                present <= 1'b1;
            else if (state_q == WR_SHUT)
                shutup <= 1'b1;
        end
    end

    // Capture the ID nybbles on the edge that samples DTACK_n low. Product nybbles are stored inverted.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            er_type    <= '0;
            er_product <= '0;
        end else if (in_bus && phase_q == PH_WAIT && !DTACK_n) begin
            case (state_q)
                RD_T0:   er_type[7:4]    <= DIN;
                RD_T1:   er_type[3:0]    <= DIN;
                RD_P0:   er_product[7:4] <= ~DIN;
                RD_P1:   er_product[3:0] <= ~DIN;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/zorro2_config_host.md
ZORRO2_CONFIG_HOST -- requirements
Module: zorro2_config_host

Interface
REQ-001 Parameters: BASE, 8'hE9, base address A23:16 assigned to a 64K board; TMO_CYC, 31, DTACK timeout in CLK cycles (5-bit counter).
REQ-002 CLK  in  1  7 MHz bus clock; all logic on rising edge.
REQ-003 RESET_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  single-cycle pulse that begins a configuration pass; ignored while busy.
REQ-005 ADDR  out  23  bus address A23:A1.
REQ-006 AS_n, UDS_n, LDS_n  out  1 each  strobes, active-low.
REQ-007 RW  out  1  1 = read, 0 = write.
REQ-008 DOUT  out  4  write data D15:D12; DOE  out  1  high while DOUT must be driven.
REQ-009 DIN  in  4  read data D15:D12.
REQ-010 DTACK_n, BERR_n  in  1 each  slave termination / bus error.
REQ-011 CFGOUT_n  out  1  drives CFGIN_n of the first card.
REQ-012 busy, done, present, shutup  out  1 each  status; er_type, er_product  out  8 each  captured ID.

Function
REQ-013 States: IDLE, RD_T0, RD_T1, RD_P0, RD_P1, WR_LO, WR_HI, WR_SHUT, FIN; each RD/WR state runs one bus cycle.
REQ-014 Bus cycle: C0 drive ADDR/RW, AS_n=UDS_n=1; C1 AS_n=0 (read: UDS_n=0 together); write: DOE=1 at C1, UDS_n=0 at C2; then wait.
REQ-015 Wait ends on first rising edge sampling DTACK_n=0 or BERR_n=0, or on timeout; next cycle AS_n=UDS_n=1; DOE=0 one cycle later; ADDR/RW hold through that cycle.
REQ-016 Read data is latched on the edge that samples DTACK_n=0; LDS_n stays 1 always.
REQ-017 Read addresses: RD_T0 $E80000, RD_T1 $E80002, RD_P0 $E80004, RD_P1 $E80006.
REQ-018 Nybbles at $00/$02 are stored as read; $04/$06 are stored inverted; er_type = {T0,T1}, er_product = {~P0,~P1}.
REQ-019 Sequence: start -> CFGOUT_n=0, busy=1, RD_T0..RD_P1 in order.
REQ-020 After RD_P1: if er_type[2:0]==3'b001 (64K) -> WR_LO ($E8004A, DOUT=BASE[3:0]) then WR_HI ($E80048, DOUT=BASE[7:4]); else -> WR_SHUT ($E8004C, DOUT=4'h0), shutup=1.
REQ-021 Bus error or timeout in any read -> present=0, skip remaining cycles, go FIN.
REQ-022 Bus error or timeout in a write -> present=1, shutup=0, go FIN.
REQ-023 Successful reads -> present=1.
REQ-024 FIN: busy=0, done=1, CFGOUT_n=1; hold status and ID until next start; start in FIN clears done, present, shutup and restarts.
REQ-025 er_type[7:6] is not checked; any value proceeds per REQ-020.

Reset
REQ-026 RESET_n=0 asynchronously forces IDLE, AS_n=UDS_n=LDS_n=RW=CFGOUT_n=1, DOE=0, ADDR=0, DOUT=0, busy=done=present=shutup=0, er_type=er_product=0, timeout counter=0.
REQ-027 Reset asserted mid-cycle releases all strobes on assertion; no cycle resumes after release; a new start is required.

Configuration
REQ-028 Macro CFG_HOST_TIMEOUT_EN.
- Defined: counter clears at C1 and increments each wait cycle; reaching TMO_CYC ends the cycle as a timeout.
- Undefined: no counter; wait ends only on DTACK_n or BERR_n.

Verification
REQ-029 Card model returns T0=4'hC, T1=4'h1, P0=4'hA, P1=4'h5, DTACK after 2 waits -> er_type=8'hC1, er_product=8'h5A, writes $4A=9, $48=E, present=1, shutup=0, done=1.
REQ-030 Type 8'hC0 (8MB) -> single write $4C data 0, shutup=1, present=1, no $48/$4A access.
REQ-031 No card, DTACK_n held 1, macro defined -> RD_T0 ends at TMO_CYC cycles after AS_n low, present=0, done=1, only one AS_n pulse.
REQ-032 BERR_n=0 during WR_HI -> strobes negate next cycle, present=1, shutup=0, done=1, CFGOUT_n=1.
REQ-033 RESET_n low during the wait of RD_P0 -> AS_n=UDS_n=1 and busy=0 with no clock edge; after release, no bus activity until start.
REQ-034 start pulsed while busy -> ignored, sequence and addresses unchanged.
